// File: rtl/scan_lbist_ctrl.sv
// Logic-BIST controller for a single scan chain: LFSR pattern source on SI,
// one capture per pattern, MISR compaction of SO into a 16-bit signature.
module scan_lbist_ctrl #(
    parameter int          CHAIN_LEN = 64,
    parameter int          NUM_PAT   = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        start,
    input  logic        abort,
    input  logic        SO,
    output logic        SE,
    output logic        SI,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PW = (NUM_PAT > 0) ? $clog2(NUM_PAT + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] LAST_PAT = PW'(NUM_PAT - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [15:0]     misr;
    logic [BW-1:0]   bit_cnt;
    logic [PW-1:0]   pat_cnt;
    logic [15:0]     lfsr_nxt;
    logic [15:0]     misr_nxt;

    assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign misr_nxt  = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10] ^ SO};
    assign SI        = (state == SHIFT) & lfsr[15];
    assign signature = misr;

    // SE/busy/done are registered alongside the state so no input reaches SE combinationally.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state   <= IDLE;
            lfsr    <= SEED;
            misr    <= 16'h0000;
            bit_cnt <= '0;
            pat_cnt <= '0;
            SE      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort && busy) begin
            state <= IDLE;
            SE    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= SHIFT;
                        lfsr    <= SEED;
                        misr    <= 16'h0000;
                        bit_cnt <= '0;
                        pat_cnt <= '0;
                        SE      <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_nxt;
                    // first load unloads pre-run chain contents, which are not compacted
                    if (pat_cnt != '0) misr <= misr_nxt;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= CAPTURE;
                        SE      <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + PW'(1);
                    SE      <= 1'b1;
                    if (pat_cnt != LAST_PAT) state <= SHIFT;
                    else                     state <= UNLOAD;
                end
                UNLOAD: begin
                    misr <= misr_nxt;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= DONE;
                        SE      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    SE    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_lbist_ctrl.sv
// Directed bench: two controllers (4-flop chain, 1 and 3 patterns) each driving
// a small behavioural scan chain whose D inputs are tied to d_val.
module tb_scan_lbist_ctrl;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        d_val = 1'b0;
    logic        start1 = 1'b0, abort1 = 1'b0;
    logic        start3 = 1'b0, abort3 = 1'b0;
    logic        se1, si1, busy1, done1, so1;
    logic        se3, si3, busy3, done3, so3;
    logic [15:0] sig1, sig3;
    logic [3:0]  ch1, ch3;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 CK = ~CK;

    scan_lbist_ctrl #(.CHAIN_LEN(4), .NUM_PAT(1), .SEED(16'hACE1)) u_dut1 (
        .CK(CK), .RN(RN), .start(start1), .abort(abort1), .SO(so1),
        .SE(se1), .SI(si1), .busy(busy1), .done(done1), .signature(sig1));

    scan_lbist_ctrl #(.CHAIN_LEN(4), .NUM_PAT(3), .SEED(16'hACE1)) u_dut3 (
        .CK(CK), .RN(RN), .start(start3), .abort(abort3), .SO(so3),
        .SE(se3), .SI(si3), .busy(busy3), .done(done3), .signature(sig3));

    always @(posedge CK) begin
        if (!RN)      ch1 <= 4'h0;
        else if (se1) ch1 <= {ch1[2:0], si1};
        else          ch1 <= {4{d_val}};
        if (!RN)      ch3 <= 4'h0;
        else if (se3) ch3 <= {ch3[2:0], si3};
        else          ch3 <= {4{d_val}};
    end
    assign so1 = ch1[3];
    assign so3 = ch3[3];

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start1;
        start1 = 1'b1; tick(); start1 = 1'b0;
    endtask

    task automatic pulse_start3;
        start3 = 1'b1; tick(); start3 = 1'b0;
    endtask

    task automatic test_reset;
        RN = 1'b0; start1 = 1'b1; start3 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({se1, si1, busy1, done1, sig1} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_dut1 cyc=%0d got se=%b si=%b busy=%b done=%b sig=%h want all 0",
                         i, se1, si1, busy1, done1, sig1);
            end
            n_cmp++;
            if ({se3, si3, busy3, done3, sig3} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_dut3 cyc=%0d got se=%b busy=%b done=%b sig=%h want all 0",
                         i, se3, busy3, done3, sig3);
            end
        end
        start1 = 1'b0; start3 = 1'b0; RN = 1'b1;
        tick();
        n_cmp++;
        if ({busy1, busy3, se1, se3} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_no_run got busy1=%b busy3=%b se1=%b se3=%b want 0", busy1, busy3, se1, se3);
        end
    endtask

    task automatic test_run_zero;
        logic [3:0] si_exp;
        logic       se_exp;
        si_exp = 4'b1010;
        d_val  = 1'b0;
        pulse_start1();
        for (int k = 0; k < 9; k++) begin
            se_exp = (k != 4);
            n_cmp++;
            if (se1 !== se_exp || busy1 !== 1'b1) begin
                n_err++;
                $display("FAIL se_seq k=%0d got se=%b busy=%b want se=%b busy=1", k, se1, busy1, se_exp);
            end
            if (k < 4) begin
                n_cmp++;
                if (si1 !== si_exp[3-k]) begin
                    n_err++;
                    $display("FAIL si_seq k=%0d got %b want %b", k, si1, si_exp[3-k]);
                end
            end
            tick();
        end
        n_cmp++;
        if ({done1, busy1, se1} !== 3'b100 || sig1 !== 16'h0000) begin
            n_err++;
            $display("FAIL run_zero_end got done=%b busy=%b se=%b sig=%h want done=1 busy=0 se=0 sig=0000",
                     done1, busy1, se1, sig1);
        end
    endtask

    task automatic test_run_ones;
        d_val = 1'b1;
        pulse_start1();
        repeat (9) tick();
        n_cmp++;
        if (done1 !== 1'b1 || sig1 !== 16'h000F) begin
            n_err++;
            $display("FAIL run_ones got done=%b sig=%h want done=1 sig=000f", done1, sig1);
        end
        start1 = 1'b1; tick(); start1 = 1'b0;
        n_cmp++;
        if ({done1, busy1, se1} !== 3'b011) begin
            n_err++;
            $display("FAIL restart got done=%b busy=%b se=%b want done=0 busy=1 se=1", done1, busy1, se1);
        end
        repeat (9) tick();
        n_cmp++;
        if (done1 !== 1'b1 || sig1 !== 16'h000F) begin
            n_err++;
            $display("FAIL reseed got done=%b sig=%h want done=1 sig=000f", done1, sig1);
        end
    endtask

    task automatic test_multi_pattern;
        int          nb;
        logic [39:0] caps;
        nb    = 0;
        caps  = '0;
        d_val = 1'b1;
        pulse_start3();
        for (int c = 0; c < 40; c++) begin
            if (busy3) nb++;
            if (busy3 && !se3) caps[c] = 1'b1;
            start3 = (c == 7);
            tick();
        end
        start3 = 1'b0;
        n_cmp++;
        if (nb != 19) begin
            n_err++;
            $display("FAIL busy_len got %0d want 19", nb);
        end
        n_cmp++;
        if (caps !== 40'h0000004210) begin
            n_err++;
            $display("FAIL capture_pos got %h want 0000004210", caps);
        end
        n_cmp++;
        if (done3 !== 1'b1 || sig3 !== 16'h0FFE) begin
            n_err++;
            $display("FAIL multi_sig got done=%b sig=%h want done=1 sig=0ffe", done3, sig3);
        end
    endtask

    task automatic test_abort_shift;
        logic [15:0] sig_before;
        pulse_start3();
        tick(); tick();
        sig_before = sig3;
        abort3 = 1'b1; tick(); abort3 = 1'b0;
        n_cmp++;
        if ({se3, busy3, done3} !== 3'b000 || sig3 !== 16'h0000 || sig3 !== sig_before) begin
            n_err++;
            $display("FAIL abort_shift got se=%b busy=%b done=%b sig=%h want 0 0 0 sig=0000",
                     se3, busy3, done3, sig3);
        end
        tick();
        n_cmp++;
        if (busy3 !== 1'b0 || sig3 !== 16'h0000) begin
            n_err++;
            $display("FAIL abort_hold got busy=%b sig=%h want busy=0 sig=0000", busy3, sig3);
        end
    endtask

    task automatic test_abort_unload;
        d_val = 1'b1;
        pulse_start1();
        repeat (7) tick();
        abort1 = 1'b1; tick(); abort1 = 1'b0;
        n_cmp++;
        if ({se1, busy1, done1} !== 3'b000 || sig1 !== 16'h0003) begin
            n_err++;
            $display("FAIL abort_unload got se=%b busy=%b done=%b sig=%h want 0 0 0 sig=0003",
                     se1, busy1, done1, sig1);
        end
        tick();
        n_cmp++;
        if (sig1 !== 16'h0003 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_unload_hold got sig=%h busy=%b want sig=0003 busy=0", sig1, busy1);
        end
    endtask

    task automatic test_start_abort_done;
        pulse_start1();
        repeat (9) tick();
        abort1 = 1'b1; tick();
        n_cmp++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_in_done got done=%b busy=%b want done=1 busy=0", done1, busy1);
        end
        start1 = 1'b1; tick(); start1 = 1'b0; abort1 = 1'b0;
        n_cmp++;
        if ({busy1, se1, done1} !== 3'b110) begin
            n_err++;
            $display("FAIL start_beats_abort got busy=%b se=%b done=%b want 1 1 0", busy1, se1, done1);
        end
    endtask

    task automatic test_reset_unload;
        repeat (6) tick();
        RN = 1'b0; start1 = 1'b1; abort1 = 1'b1; tick();
        start1 = 1'b0; abort1 = 1'b0; RN = 1'b1;
        n_cmp++;
        if ({se1, si1, busy1, done1, sig1} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_unload got se=%b si=%b busy=%b done=%b sig=%h want all 0",
                     se1, si1, busy1, done1, sig1);
        end
        tick();
        n_cmp++;
        if (busy1 !== 1'b0 || se1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_unload_idle got busy=%b se=%b want 0 0", busy1, se1);
        end
    endtask

    initial begin
        test_reset();
        test_run_zero();
        test_run_ones();
        test_multi_pattern();
        test_abort_shift();
        test_abort_unload();
        test_start_abort_done();
        test_reset_unload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_lbist_ctrl.md
# scan_lbist_ctrl

Logic-BIST scan controller that drives one scan chain built from scan flip-flops with active-low reset. It generates the chain's scan-enable and scan-in signals from an internal 16-bit LFSR. It issues one capture cycle per pattern and compacts the chain's scan-out into a 16-bit MISR signature. It sits directly upstream of the chain (SE/SI sources) and downstream of it (SO sink), with the same CK as the chain flops.

## Interface
- CHAIN_LEN, 64: number of flops in the chain; legal range ≥ 2.
- NUM_PAT, 16: patterns per run; legal range ≥ 1.
- SEED, 16'hACE1: LFSR load value; must be nonzero.
- CK  in  1  clock; all state changes on the rising edge.
- RN  in  1  reset; synchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- abort  in  1  terminate the run; sampled while busy.
- SO  in  1  scan-out, the Q of the last chain flop.
- SE  out  1  scan enable to every chain flop.
- SI  out  1  scan-in to the first chain flop.
- busy  out  1  run in progress.
- done  out  1  run completed normally; signature is valid.
- signature  out  16  MISR contents.

## Operation
- States:
  - IDLE: entered from reset.
  - SHIFT: load pattern p while unloading the response of pattern p-1.
  - CAPTURE: one cycle.
  - UNLOAD: final response unload.
  - DONE.
- Transitions:
  - IDLE/DONE + start → SHIFT. LFSR ← SEED, MISR ← 0, bit_cnt ← 0, pat_cnt ← 0.
  - SHIFT after CHAIN_LEN cycles → CAPTURE.
  - CAPTURE → SHIFT if pat_cnt+1 < NUM_PAT; otherwise → UNLOAD. pat_cnt increments in CAPTURE.
  - UNLOAD after CHAIN_LEN cycles → DONE.
  - Any busy state + abort → IDLE.
- SE = 1 in SHIFT and UNLOAD, 0 elsewhere. SE is decoded from the state register only; there is no combinational path from any input to SE.
- SI = lfsr[15] in SHIFT, 0 elsewhere.
- LFSR advances only in SHIFT: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- MISR ← {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]^SO}.
  - Updates in UNLOAD, and in SHIFT when pat_cnt > 0.
  - Does not update in the first SHIFT, because pre-run chain contents are excluded.
- signature = MISR register at all times. It holds after DONE and after abort.
- busy = 1 in SHIFT, CAPTURE and UNLOAD.
- done = 1 in DONE only. It clears on the cycle start is accepted.
- start is ignored while busy.
- abort has priority over every transition. Abort in IDLE/DONE is ignored.
- Counter widths:
  - bit_cnt: $clog2(CHAIN_LEN) bits.
  - pat_cnt: $clog2(NUM_PAT+1) bits.
  - Counters never wrap mid-run.

## Timing
- Reset values (RN=0 at an edge): state IDLE, SE=0, SI=0, busy=0, done=0, signature=16'h0000, LFSR=SEED, counters 0. Reset mid-run has the same effect and overrides start and abort.
- start sampled high at edge 0 → SE=1, busy=1 from edge 0 until the end of the run.
- The chain shifts at each edge where SE=1. The MISR samples SO at that same edge.
- Run length from start acceptance to done=1: NUM_PAT·(CHAIN_LEN+1) + CHAIN_LEN cycles.
- done rises the cycle after the last UNLOAD edge.
- abort sampled high → IDLE next cycle: SE=0, busy=0, done=0.
- start and abort high together in DONE: start wins.

## Test plan
- Reset: RN=0 for 2 cycles with start=1 → SE=0, SI=0, busy=0, done=0, signature=16'h0000. No run starts until RN=1.
- CHAIN_LEN=4, NUM_PAT=1, chain of 4 scan flops with D tied 0, start pulse:
  - SE sequence 1,1,1,1,0,1,1,1,1, then done=1 after 9 cycles.
  - SI during SHIFT = 1,0,1,0 (SEED 16'hACE1).
  - signature = 16'h0000.
- Same setup with D tied 1:
  - Capture loads ones; unload shifts out four 1s.
  - signature = 16'h000F.
  - Second start → identical signature (re-seed check).
- CHAIN_LEN=4, NUM_PAT=3 → busy high exactly 19 cycles; three CAPTURE cycles (SE=0) spaced 5 cycles apart.
- abort asserted on the 3rd SHIFT cycle → next cycle SE=0, busy=0, done=0, signature unchanged; a start pulse during the run is ignored.
- RN=0 during UNLOAD → next cycle IDLE with all outputs at reset values.
